rle_encode: RTL
===============

RLE_ENCODE -- requirements
Module: rle_encode

Interface
REQ-001 The block SHALL have parameter data_width_p, default 2, meaning the symbol width.
REQ-002 The block SHALL have parameter bus_width_p, default 8, meaning the packed pair width.
REQ-003 The block SHALL have parameter count_width_p, default bus_width_p - data_width_p, meaning the run-count width; MAX = 2^count_width_p - 1.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port data_i, input, data_width_p bits: the input symbol.
REQ-007 The block SHALL have port last_i, input, 1 bit: marks the final symbol of a frame.
REQ-008 The block SHALL have port valid_i, input, 1 bit, and port ready_o, output, 1 bit: the input handshake.
REQ-009 The block SHALL have port rle_value_o, output, data_width_p bits: the run symbol.
REQ-010 The block SHALL have port rle_count_o, output, count_width_p bits: the run length, 1..MAX.
REQ-011 The block SHALL have port last_o, output, 1 bit: marks the final pair of a frame.
REQ-012 The block SHALL have port valid_o, output, 1 bit, and port ready_i, input, 1 bit: the output handshake.

Function
REQ-013 An input fire SHALL be valid_i && ready_o; an output fire SHALL be valid_o && ready_i.
REQ-014 The FSM SHALL have exactly three states: IDLE (no open run), RUN (run_value_r/run_count_r open), FLUSH (one pending singleton pair).
REQ-015 The output stage SHALL be a one-entry register; ready_o = (output stage empty || ready_i) && state != FLUSH.
REQ-016 A fire in IDLE with last_i=0 SHALL open a run: value=data_i, count=1, go to RUN, emit nothing.
REQ-017 A fire in IDLE with last_i=1 SHALL emit (data_i, 1, last=1) and stay in IDLE.
REQ-018 A fire in RUN with data_i==run_value_r, count<MAX and last_i=0 SHALL increment count and emit nothing.
REQ-019 A fire in RUN with data_i==run_value_r, count<MAX and last_i=1 SHALL emit (run_value_r, count+1, last=1) and go to IDLE.
REQ-020 A fire in RUN with a different symbol, or with count==MAX, and last_i=0 SHALL emit (run_value_r, count, last=0) and open a new run (data_i, 1).
REQ-021 A fire in RUN with a different symbol or count==MAX, and last_i=1 SHALL emit (run_value_r, count, last=0), latch data_i as the pending singleton, and go to FLUSH.
REQ-022 FLUSH SHALL present (pending, 1, last=1) as soon as the output stage frees, then go to IDLE; ready_o SHALL be 0 throughout FLUSH.
REQ-023 An emitted pair SHALL appear on valid_o the cycle after the terminating input fire (latency 1).
REQ-024 valid_o SHALL hold, with value/count/last stable, until the output fires (no drop, no change under back-pressure).
REQ-025 rle_count_o SHALL never be 0; count increments SHALL never wrap (saturation at MAX forces emission per REQ-020/021).
REQ-026 Input fires SHALL be stalled whenever the output stage is full and ready_i=0, even if the fire would only extend the run.
REQ-027 Full throughput SHALL be sustained: with ready_i held at 1, ready_o SHALL remain 1 outside FLUSH.

Reset
REQ-028 While reset_i=1 at a clock edge, the block SHALL set state=IDLE, run_count_r=0, run_value_r=0, and clear the pending singleton.
REQ-029 Reset SHALL force valid_o=0, rle_value_o=0, rle_count_o=0, last_o=0, and ready_o=1 on the first cycle after reset.
REQ-030 A reset asserted mid-run or mid-FLUSH SHALL discard the partial run without emitting it.

Structure
REQ-031 A shared package rle_pkg SHALL hold the state enum typedef (IDLE/RUN/FLUSH) and the MAX-count computation function.
REQ-032 The output register SHALL be the existing elastic module, width data_width_p+count_width_p+1, with datapath gating and datapath reset enabled; there SHALL be no other sub-module.

Verification (data_width_p=2, count_width_p=6, MAX=63)
REQ-033 The bench SHALL drive 1,1,1,2(last), ready_i=1 -> (1,3,0) then (2,1,1), with ready_o=0 for exactly one cycle.
REQ-034 The bench SHALL drive 70 symbols of 3, last on the 70th -> (3,63,0) then (3,7,1).
REQ-035 The bench SHALL drive single 0(last) -> (0,1,1) one cycle later, with the FSM back in IDLE.
REQ-036 The bench SHALL drive 0,1,2,3(last) with ready_i toggling randomly -> (0,1,0),(1,1,0),(2,1,0),(3,1,1), outputs stable while stalled, no loss.
REQ-037 The bench SHALL drive 2,2,2, assert reset, then drive 1(last) -> only (1,1,1) emitted; valid_o=0 during and after reset.
REQ-038 The bench SHALL connect rle_encode to rle_decode with random streams of up to 1000 symbols -> decoded stream identical to the input.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and helpers for the run-length encoder.
package rle_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   // Largest run length a count field of the given width can hold.
   function automatic int unsigned max_count(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/rle_encode_elastic.sv
// One-entry elastic output register with optional load gating
// and optional datapath reset.
module rle_encode_elastic #(
   parameter int width_p      = 9,
   parameter bit gate_p       = 1'b1,
   parameter bit reset_data_p = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push_valid,
   input  logic [width_p-1:0] push_data,
   output logic               push_ready,
   output logic               pop_valid,
   output logic [width_p-1:0] pop_data,
   input  logic               pop_ready
);

   logic               full;
   logic [width_p-1:0] data;
   logic               load;
   logic               take;

   assign push_ready = !full || pop_ready;
   assign load       = push_valid && push_ready;
   assign take       = gate_p ? load : push_ready;
   assign pop_valid  = full;
   assign pop_data   = data;

   always_ff @(posedge clk) begin
      if (reset) begin
         full <= 1'b0;
      end else if (push_ready) begin
         full <= push_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && reset_data_p) begin
         data <= '0;
      end else if (take) begin
         data <= push_data;
      end
   end

endmodule

// File: rtl/rle_encode.sv
// Streaming run-length encoder: symbols in, (value, count, last)
// pairs out through a one-entry elastic register.
module rle_encode
   import rle_pkg::*;
#(
   parameter int data_width_p  = 2,
   parameter int bus_width_p   = 8,
   parameter int count_width_p = bus_width_p - data_width_p
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [data_width_p-1:0]  data_i,
   input  logic                     last_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic [data_width_p-1:0]  rle_value_o,
   output logic [count_width_p-1:0] rle_count_o,
   output logic                     last_o,
   output logic                     valid_o,
   input  logic                     ready_i
);

   localparam int pair_w = data_width_p + count_width_p + 1;
   localparam logic [count_width_p-1:0] max_c =
      count_width_p'(max_count(count_width_p));
   localparam logic [count_width_p-1:0] one_c =
      count_width_p'(1);

   state_t                     state, state_n;
   logic [data_width_p-1:0]    run_value_r, run_value_n;
   logic [count_width_p-1:0]   run_count_r, run_count_n;
   logic [data_width_p-1:0]    pending, pending_n;

   logic                       space;
   logic                       fire;
   logic                       same;
   logic                       emit;
   logic [data_width_p-1:0]    emit_value;
   logic [count_width_p-1:0]   emit_count;
   logic                       emit_last;
   logic [pair_w-1:0]          pair;

   assign ready_o = space && (state != FLUSH);
   assign fire    = valid_i && ready_o;
   assign same    = (data_i == run_value_r) && (run_count_r < max_c);

   always_comb begin
      state_n     = state;
      run_value_n = run_value_r;
      run_count_n = run_count_r;
      pending_n   = pending;
      emit        = 1'b0;
      emit_value  = run_value_r;
      emit_count  = run_count_r;
      emit_last   = 1'b0;
      unique case (state)
         IDLE: begin
            if (fire && last_i) begin
               emit       = 1'b1;
               emit_value = data_i;
               emit_count = one_c;
               emit_last  = 1'b1;
            end else if (fire) begin
               run_value_n = data_i;
               run_count_n = one_c;
               state_n     = RUN;
            end
         end
         RUN: begin
            if (fire && same && !last_i) begin
               run_count_n = run_count_r + one_c;
            end else if (fire && same) begin
               emit       = 1'b1;
               emit_count = run_count_r + one_c;
               emit_last  = 1'b1;
               state_n    = IDLE;
            end else if (fire && !last_i) begin
               emit        = 1'b1;
               run_value_n = data_i;
               run_count_n = one_c;
            end else if (fire) begin
               emit      = 1'b1;
               pending_n = data_i;
               state_n   = FLUSH;
            end
         end
         FLUSH: begin
            // The singleton leaves as soon as the output slot frees.
            if (space) begin
               emit       = 1'b1;
               emit_value = pending;
               emit_count = one_c;
               emit_last  = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= IDLE;
         run_value_r <= '0;
         run_count_r <= '0;
         pending     <= '0;
      end else begin
         state       <= state_n;
         run_value_r <= run_value_n;
         run_count_r <= run_count_n;
         pending     <= pending_n;
      end
   end

   rle_encode_elastic #(
      .width_p      (pair_w),
      .gate_p       (1'b1),
      .reset_data_p (1'b1)
   ) out_reg (
      .clk        (clk_i),
      .reset      (reset_i),
      .push_valid (emit),
      .push_data  ({emit_value, emit_count, emit_last}),
      .push_ready (space),
      .pop_valid  (valid_o),
      .pop_data   (pair),
      .pop_ready  (ready_i)
   );

   assign {rle_value_o, rle_count_o, last_o} = pair;

endmodule
